// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - write/read port bundle for register_file
interface register_file_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              write_enable;
    logic [ADDR_W-1:0] write_addr;
    logic [WIDTH-1:0]  write_data;
    logic              read_enable;
    logic [ADDR_W-1:0] read_addr_a;
    logic [ADDR_W-1:0] read_addr_b;
    logic [WIDTH-1:0]  read_data_a;
    logic [WIDTH-1:0]  read_data_b;

    modport master (
        output write_enable, write_addr, write_data,
        output read_enable, read_addr_a, read_addr_b,
        input  read_data_a, read_data_b
    );

    modport slave (
        input  write_enable, write_addr, write_data,
        input  read_enable, read_addr_a, read_addr_b,
        output read_data_a, read_data_b
    );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - DEPTH x WIDTH register file, one write port, two read ports
module register_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0
) (
    input  logic          clock,
    input  logic          clear,
    register_file_if.slave bus
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_legal;
    logic [WIDTH-1:0] val_a;
    logic [WIDTH-1:0] val_b;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < 32'(DEPTH);
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // A write only lands when it targets a real, writable entry
    always_comb begin
        wr_legal = bus.write_enable && in_range(bus.write_addr) && !is_zero_reg(bus.write_addr);
    end

    // Next-state storage: only the addressed entry changes; decoded per entry so
    // out-of-range addresses never form an array index
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_legal && (bus.write_addr == ADDR_W'(i))) begin
                mem_d[i] = bus.write_data;
            end
        end
    end

    // Storage flops, cleared asynchronously
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read value per port: decoded lookup, then optional bypass, forced to 0 during clear
    always_comb begin
        val_a = '0;
        val_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((bus.read_addr_a == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
                val_a = mem_q[i];
            end
            if ((bus.read_addr_b == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
                val_b = mem_q[i];
            end
        end
        if ((BYPASS != 0) && wr_legal && (bus.read_addr_a == bus.write_addr)) begin
            val_a = bus.write_data;
        end
        if ((BYPASS != 0) && wr_legal && (bus.read_addr_b == bus.write_addr)) begin
            val_b = bus.write_data;
        end
        if (!clear) begin
            val_a = '0;
            val_b = '0;
        end
    end

    generate
        if (READ_REG != 0) begin : g_read_reg
            logic [WIDTH-1:0] rd_a_q;
            logic [WIDTH-1:0] rd_a_d;
            logic [WIDTH-1:0] rd_b_q;
            logic [WIDTH-1:0] rd_b_d;

            // Read registers load on read_enable and otherwise hold (stall)
            always_comb begin
                rd_a_d = bus.read_enable ? val_a : rd_a_q;
                rd_b_d = bus.read_enable ? val_b : rd_b_q;
            end

            // Read register flops, cleared asynchronously with the storage
            always_ff @(posedge clock or negedge clear) begin
                if (!clear) begin
                    rd_a_q <= '0;
                    rd_b_q <= '0;
                end else begin
                    rd_a_q <= rd_a_d;
                    rd_b_q <= rd_b_d;
                end
            end

            assign bus.read_data_a = rd_a_q;
            assign bus.read_data_b = rd_b_q;
        end else begin : g_read_comb
            assign bus.read_data_a = val_a;
            assign bus.read_data_b = val_b;
        end
    endgenerate

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - randomized + directed bench for register_file against a reference model
module tb_register_file;

    logic clock;
    logic clear;

    logic        cur_we;
    logic [4:0]  cur_wa;
    logic [31:0] cur_wd;
    logic        cur_re;
    logic [4:0]  cur_ra;
    logic [4:0]  cur_rb;

    int n_tests;
    int n_fail;

    // Reference state: cfg0 = DEPTH 32, ZERO_REG 1, BYPASS 1, comb read
    //                  cfg1 = DEPTH 24, ZERO_REG 0, BYPASS 0, registered read
    logic [31:0] m0 [32];
    logic [31:0] m1 [32];
    logic [31:0] r1a;
    logic [31:0] r1b;

    register_file_if #(.WIDTH(32), .ADDR_W(5)) bus0 ();
    register_file_if #(.WIDTH(32), .ADDR_W(5)) bus1 ();

    assign bus0.write_enable = cur_we;
    assign bus0.write_addr   = cur_wa;
    assign bus0.write_data   = cur_wd;
    assign bus0.read_enable  = cur_re;
    assign bus0.read_addr_a  = cur_ra;
    assign bus0.read_addr_b  = cur_rb;
    assign bus1.write_enable = cur_we;
    assign bus1.write_addr   = cur_wa;
    assign bus1.write_data   = cur_wd;
    assign bus1.read_enable  = cur_re;
    assign bus1.read_addr_a  = cur_ra;
    assign bus1.read_addr_b  = cur_rb;

    register_file #(
        .WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1), .READ_REG(0)
    ) u_rf0 (
        .clock(clock), .clear(clear), .bus(bus0.slave)
    );

    register_file #(
        .WIDTH(32), .DEPTH(24), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0), .READ_REG(1)
    ) u_rf1 (
        .clock(clock), .clear(clear), .bus(bus1.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit write_ok(input int cfg);
        int depth;
        bit zr;
        depth = (cfg == 0) ? 32 : 24;
        zr    = (cfg == 0);
        return cur_we && (int'(cur_wa) < depth) && !(zr && cur_wa == 5'd0);
    endfunction

    function automatic logic [31:0] expect_read(input int cfg, input logic [4:0] addr);
        int depth;
        bit zr;
        depth = (cfg == 0) ? 32 : 24;
        zr    = (cfg == 0);
        if (cfg == 0 && write_ok(0) && addr == cur_wa) return cur_wd;
        if (int'(addr) >= depth || (zr && addr == 5'd0)) return 32'h0;
        return (cfg == 0) ? m0[addr] : m1[addr];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m0[i] = 32'h0;
            m1[i] = 32'h0;
        end
        r1a = 32'h0;
        r1b = 32'h0;
    endtask

    // One clock cycle: drive, check mid-cycle, advance the model across the edge
    task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] ra, input logic [4:0] rb);
        cur_we = we;
        cur_wa = wa;
        cur_wd = wd;
        cur_re = re;
        cur_ra = ra;
        cur_rb = rb;
        @(negedge clock);
        check_eq("rf0_read_a", bus0.read_data_a, expect_read(0, ra));
        check_eq("rf0_read_b", bus0.read_data_b, expect_read(0, rb));
        check_eq("rf1_read_a", bus1.read_data_a, r1a);
        check_eq("rf1_read_b", bus1.read_data_b, r1b);
        if (re) begin
            r1a = expect_read(1, ra);
            r1b = expect_read(1, rb);
        end
        if (write_ok(0)) m0[wa] = wd;
        if (write_ok(1)) m1[wa] = wd;
        @(posedge clock);
        #1;
    endtask

    // Asynchronous clear mid-cycle; optionally held across an edge carrying a write to entry 9
    task automatic pulse_clear(input bit across_edge);
        #2;
        clear = 1'b0;
        #1;
        model_clear();
        check_eq("clr_rf0_a", bus0.read_data_a, 32'h0);
        check_eq("clr_rf0_b", bus0.read_data_b, 32'h0);
        check_eq("clr_rf1_a", bus1.read_data_a, 32'h0);
        check_eq("clr_rf1_b", bus1.read_data_b, 32'h0);
        if (across_edge) begin
            cur_we = 1'b1;
            cur_wa = 5'd9;
            cur_wd = 32'h99999999;
            cur_re = 1'b1;
            cur_ra = 5'd9;
            cur_rb = 5'd9;
            @(posedge clock);
            #1;
            check_eq("clr_edge_rf0_a", bus0.read_data_a, 32'h0);
            check_eq("clr_edge_rf1_a", bus1.read_data_a, 32'h0);
        end
        cur_we = 1'b0;
        cur_re = 1'b0;
        #1;
        clear = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [4:0]  wa;
        logic [4:0]  ra;
        n_tests = 0;
        n_fail  = 0;
        clear   = 1'b0;
        cur_we  = 1'b0;
        cur_wa  = '0;
        cur_wd  = '0;
        cur_re  = 1'b0;
        cur_ra  = '0;
        cur_rb  = '0;
        model_clear();
        #3;
        check_eq("reset_rf0_a", bus0.read_data_a, 32'h0);
        check_eq("reset_rf0_b", bus0.read_data_b, 32'h0);
        check_eq("reset_rf1_a", bus1.read_data_a, 32'h0);
        check_eq("reset_rf1_b", bus1.read_data_b, 32'h0);
        #1;
        clear = 1'b1;
        @(posedge clock);
        #1;

        // Reset hold: entry 5 loaded and visible, then cleared with no edge
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd5);
        pulse_clear(1'b0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5);

        // Basic write/read on entry 7, both ports
        cycle(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7);
        check_eq("basic_rf1_a", bus1.read_data_a, 32'h12345678);

        // Zero register: entry 0 write
        cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
        check_eq("zero_rf1_a", bus1.read_data_a, 32'hFFFFFFFF);

        // Bypass versus old contents on entry 3
        cycle(1'b1, 5'd3, 32'h11111111, 1'b0, 5'd0, 5'd0);
        cycle(1'b1, 5'd3, 32'h22222222, 1'b1, 5'd3, 5'd3);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3);

        // Bounds: address 30 is in range for cfg0 only
        cycle(1'b1, 5'd30, 32'hAAAAAAAA, 1'b1, 5'd30, 5'd30);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd30, 5'd30);
        for (int a = 0; a < 24; a++) begin
            cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 5'(a));
        end

        // Stall: read registers hold while address and contents change
        cycle(1'b1, 5'd4, 32'h44444444, 1'b0, 5'd0, 5'd4);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd4);
        cycle(1'b1, 5'd4, 32'h55555555, 1'b0, 5'd0, 5'd4);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4);
        check_eq("stall_rf1_b", bus1.read_data_b, 32'h44444444);

        // Clear coincident with a write to entry 9
        cycle(1'b1, 5'd9, 32'h0BADF00D, 1'b0, 5'd9, 5'd9);
        pulse_clear(1'b1);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9);
        check_eq("clr_write_rf1_a", bus1.read_data_a, 32'h0);

        // Randomized traffic with frequent same-address read/write
        for (int n = 0; n < 400; n++) begin
            wa = 5'($urandom_range(0, 31));
            ra = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) ra = wa;
            cycle(1'($urandom_range(0, 1)), wa, $urandom,
                  1'($urandom_range(0, 1)), ra, 5'($urandom_range(0, 31)));
        end

        // Final sweep of every address on both ports
        for (int a = 0; a < 32; a++) begin
            cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 5'(31 - a));
        end
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
